alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 163 ++++++++++++++++
 tb/tb_alu_mc.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU: add/sub/logic/mov in one EXEC cycle, bit-serial shifts, optional shift-add MUL (ALU_MC_MUL_EN).
// Latency: done 2 cycles after the start edge; shifts N+1 (N>0), MUL WIDTH+1.
// Backpressure: start is ignored while busy; no queuing, res/out_flg hold until the next done.
module alu_mc #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] arg1,
    input  logic [WIDTH-1:0] arg2,
    input  logic [4:0]       in_flg,
    input  logic             block_cy_ov,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic [4:0]       out_flg
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t state, state_nxt;

    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             flg_cy_q, flg_ov_q, blk_q;
    logic [CW-1:0]    cnt, cnt_ld;
    logic             accept, fin;
    logic [WIDTH-1:0] r_val, sh_val;
    logic             cy_val, ov_val, sh_out, extra;
    logic [WIDTH:0]   sum, dif;
    logic [4:0]       flg_val;
    logic             unused_flg;

    // Z, S and P of the incoming flags never feed the result.
    assign unused_flg = ^{in_flg[4], in_flg[2:1]};

    assign accept = start && (state != EXEC);
    // cnt is 0 for single-cycle ops, so they always finish on the first EXEC cycle.
    assign fin    = (cnt <= CW'(1));
    assign busy   = (state == EXEC);
    assign done   = (state == DONE);

    assign extra = blk_q & flg_cy_q;
    assign sum   = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, extra};
    assign dif   = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, extra};
    assign {sh_out, sh_val} = op_q[0] ? {a_q[0], 1'b0, a_q[WIDTH-1:1]} : {a_q, 1'b0};

`ifdef ALU_MC_MUL_EN
    logic [WIDTH-1:0] mul_hi, mul_hi_nxt, mul_lo_nxt;
    logic [WIDTH:0]   mul_sum;
    // Product lives in {mul_hi, b_q}; the multiplier shifts out of b_q as the product shifts in.
    assign mul_sum    = {1'b0, mul_hi} + {1'b0, (b_q[0] ? a_q : {WIDTH{1'b0}})};
    assign mul_hi_nxt = mul_sum[WIDTH:1];
    assign mul_lo_nxt = {mul_sum[0], b_q[WIDTH-1:1]};
`endif

    always_comb begin
        cnt_ld = '0;
        if (opcode == 4'd8 || opcode == 4'd9)
            cnt_ld = CW'(arg2[SW-1:0]);
`ifdef ALU_MC_MUL_EN
        if (opcode == 4'd10)
            cnt_ld = CW'(WIDTH);
`endif
    end

    always_comb begin
        r_val  = b_q;
        cy_val = flg_cy_q;
        ov_val = flg_ov_q;
        case (op_q)
            4'd0: begin
                r_val  = sum[WIDTH-1:0];
                cy_val = sum[WIDTH];
                ov_val = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            4'd1: begin
                r_val  = dif[WIDTH-1:0];
                cy_val = dif[WIDTH];
                ov_val = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif[WIDTH-1] != a_q[WIDTH-1]);
            end
            4'd2: begin r_val = a_q & b_q; cy_val = 1'b0; ov_val = 1'b0; end
            4'd3: begin r_val = a_q | b_q; cy_val = 1'b0; ov_val = 1'b0; end
            4'd4: begin r_val = a_q ^ b_q; cy_val = 1'b0; ov_val = 1'b0; end
            4'd5: begin r_val = ~a_q;      cy_val = 1'b0; ov_val = 1'b0; end
            4'd8, 4'd9: begin
                r_val  = (cnt == '0) ? a_q : sh_val;
                cy_val = (cnt != '0) && sh_out;
                ov_val = 1'b0;
            end
`ifdef ALU_MC_MUL_EN
            4'd10: begin r_val = mul_lo_nxt; cy_val = |mul_hi_nxt; ov_val = 1'b0; end
`endif
            default: ;
        endcase
        if (blk_q) begin
            cy_val = flg_cy_q;
            ov_val = flg_ov_q;
        end
        flg_val = {~|r_val, cy_val, r_val[WIDTH-1], ^r_val, ov_val};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = EXEC;
            EXEC:    if (fin)   state_nxt = DONE;
            DONE:    state_nxt = start ? EXEC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            flg_cy_q <= 1'b0;
            flg_ov_q <= 1'b0;
            blk_q    <= 1'b0;
            cnt      <= '0;
            res      <= '0;
            out_flg  <= '0;
`ifdef ALU_MC_MUL_EN
            mul_hi   <= '0;
`endif
        end else if (accept) begin
            op_q     <= opcode;
            a_q      <= arg1;
            b_q      <= arg2;
            flg_cy_q <= in_flg[3];
            flg_ov_q <= in_flg[0];
            blk_q    <= block_cy_ov;
            cnt      <= cnt_ld;
`ifdef ALU_MC_MUL_EN
            mul_hi   <= '0;
`endif
        end else if (state == EXEC) begin
            if (fin) begin
                res     <= r_val;
                out_flg <= flg_val;
            end else begin
                cnt <= cnt - CW'(1);
                if (op_q == 4'd8 || op_q == 4'd9)
                    a_q <= sh_val;
`ifdef ALU_MC_MUL_EN
                if (op_q == 4'd10) begin
                    mul_hi <= mul_hi_nxt;
                    b_q    <= mul_lo_nxt;
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Randomized bench for alu_mc (WIDTH=16) against an arithmetic reference model and a timing scoreboard.
module tb_alu_mc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  opcode = '0;
    logic [15:0] arg1 = '0, arg2 = '0;
    logic [4:0]  in_flg = '0;
    logic        block_cy_ov = 1'b0;
    logic        busy, done;
    logic [15:0] res;
    logic [4:0]  out_flg;

    alu_mc #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .arg1(arg1), .arg2(arg2),
        .in_flg(in_flg), .block_cy_ov(block_cy_ov), .busy(busy), .done(done),
        .res(res), .out_flg(out_flg)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] r; logic [4:0] f; int start; int due; } exp_t;
    exp_t q[$];
    int checks = 0, passes = 0, cyc = 0;
    bit chk_en = 1'b0;
    logic [15:0] last_r = '0;
    logic [4:0]  last_f = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    // Reference: result, flags {Z,CY,S,P,OV} and done latency, from plain arithmetic.
    function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                  input logic [4:0] fl, input logic blk,
                                  output logic [15:0] r, output logic [4:0] f, output int lat);
        int n;
        longint t;
        logic cy, ov;
        n = int'(b[3:0]);
        cy = 1'b0; ov = 1'b0; lat = 2; r = b;
        case (op)
            4'd0: begin
                t = longint'(a) + longint'(b) + longint'(blk & fl[3]);
                r = t[15:0]; cy = t[16]; ov = (a[15] == b[15]) && (r[15] != a[15]);
            end
            4'd1: begin
                t = longint'(a) - longint'(b) - longint'(blk & fl[3]);
                r = t[15:0]; cy = (t < 0); ov = (a[15] != b[15]) && (r[15] != a[15]);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~a;
            4'd8: begin
                t = longint'(a) << n;
                r = t[15:0]; cy = (n != 0) && t[16];
                if (n != 0) lat = n + 1;
            end
            4'd9: begin
                r = a >> n;
                if (n != 0) begin cy = a[n-1]; lat = n + 1; end
            end
`ifdef ALU_MC_MUL_EN
            4'd10: begin
                t = longint'(a) * longint'(b);
                r = t[15:0]; cy = (t[31:16] != 0); lat = 17;
            end
`endif
            default: begin r = b; cy = fl[3]; ov = fl[0]; end
        endcase
        if (blk) begin cy = fl[3]; ov = fl[0]; end
        f = {r == 16'h0, cy, r[15], ^r, ov};
    endfunction

    // Scoreboard: done/busy timing every cycle, and res/out_flg holding their last valid value.
    always @(negedge clk) begin
        bit ed, eb;
        if (chk_en) begin
            ed = (q.size() > 0) && (q[0].due == cyc);
            eb = (q.size() > 0) && (cyc > q[0].start) && (cyc < q[0].due);
            check("done", done, ed);
            check("busy", busy, eb);
            if (ed) begin
                last_r = q[0].r;
                last_f = q[0].f;
                void'(q.pop_front());
            end
            check("res", res, last_r);
            check("out_flg", out_flg, last_f);
        end
    end

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic scramble();
        opcode = 4'($urandom); arg1 = 16'($urandom); arg2 = 16'($urandom);
        in_flg = 5'($urandom); block_cy_ov = 1'($urandom);
    endtask

    // Called at a negedge; waits for an idle slot, issues one op, optionally a spurious start while busy.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [4:0] fl, input logic blk, input bit spur);
        int waited = 0;
        logic [15:0] r;
        logic [4:0] f;
        int lat;
        while (busy && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (busy) begin
            check("idle_timeout", 1'b1, 1'b0);
        end else begin
            model(op, a, b, fl, blk, r, f, lat);
            q.push_back('{r, f, cyc, cyc + lat});
            start = 1'b1; opcode = op; arg1 = a; arg2 = b; in_flg = fl; block_cy_ov = blk;
            @(negedge clk);
            scramble();
            start = spur;
            if (spur) opcode = 4'd0;
            @(negedge clk);
            start = 1'b0;
            scramble();
        end
    endtask

    logic [15:0] mr;
    logic [4:0]  mf;
    int          ml;

    initial begin
        // Hand-computed expectations pinning the model.
        model(4'd0, 16'h7FFF, 16'h0001, 5'b00000, 1'b0, mr, mf, ml);
        check("pin_add_res", mr, 16'h8000); check("pin_add_flg", mf, 5'b00111); check("pin_add_lat", ml, 2);
        model(4'd1, 16'h0000, 16'h0001, 5'b01000, 1'b1, mr, mf, ml);
        check("pin_sub_res", mr, 16'hFFFE); check("pin_sub_flg", mf, 5'b01110);
        model(4'd8, 16'h8001, 16'h0003, 5'b00000, 1'b0, mr, mf, ml);
        check("pin_shl3_res", mr, 16'h0008); check("pin_shl3_flg", mf, 5'b00010); check("pin_shl3_lat", ml, 4);
        model(4'd8, 16'h8001, 16'h0001, 5'b00000, 1'b0, mr, mf, ml);
        check("pin_shl1_res", mr, 16'h0002); check("pin_shl1_flg", mf, 5'b01010);
        model(4'd9, 16'h00F0, 16'h0005, 5'b00000, 1'b0, mr, mf, ml);
        check("pin_shr_res", mr, 16'h0007); check("pin_shr_flg", mf, 5'b01010); check("pin_shr_lat", ml, 6);
        model(4'd10, 16'h0100, 16'h0100, 5'b00000, 1'b0, mr, mf, ml);
`ifdef ALU_MC_MUL_EN
        check("pin_mul_res", mr, 16'h0000); check("pin_mul_flg", mf, 5'b11000); check("pin_mul_lat", ml, 17);
`else
        check("pin_mul_res", mr, 16'h0100); check("pin_mul_flg", mf, 5'b00010); check("pin_mul_lat", ml, 2);
`endif

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0); check("rst_done", done, 1'b0);
        check("rst_res", res, 16'h0); check("rst_flg", out_flg, 5'h0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        issue(4'd0, 16'h7FFF, 16'h0001, 5'b00000, 1'b0, 1'b0);
        issue(4'd1, 16'h0000, 16'h0001, 5'b01000, 1'b1, 1'b0);
        issue(4'd8, 16'h8001, 16'h0003, 5'b00000, 1'b0, 1'b0);
        issue(4'd8, 16'h8001, 16'h0001, 5'b00000, 1'b0, 1'b0);
        issue(4'd9, 16'hABCD, 16'h0005, 5'b00000, 1'b0, 1'b1);
        issue(4'd10, 16'h0100, 16'h0100, 5'b00000, 1'b0, 1'b0);

        // Abort a long shift with reset: outputs clear at once and no done follows.
        issue(4'd8, 16'h1234, 16'h000A, 5'b00000, 1'b0, 1'b0);
        @(negedge clk);
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0); check("abort_done", done, 1'b0);
        check("abort_res", res, 16'h0); check("abort_flg", out_flg, 5'h0);
        q.delete();
        last_r = '0;
        last_f = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (20) @(negedge clk);
        issue(4'd0, 16'h7FFF, 16'h0001, 5'b00000, 1'b0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                scramble();
                start = 1'b0;
            end
            issue(4'($urandom), pick(), ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : pick(),
                  5'($urandom), 1'($urandom_range(0, 3) == 0), $urandom_range(0, 3) == 0);
        end

        for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("drain", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
